// File: rtl/sobel_scheduler.sv
// ---------------------------------------------------------------------------
// sobel_scheduler
//
// Walks a frame stored in a synchronous-read memory as vertical 3-column
// strips and streams 3x3 windows to a Sobel controller. The first window of
// a strip fetches all nine pixels. Each following window fetches only the
// new bottom row of three pixels. After the last pixel of a window the
// scheduler waits for the Sobel result (stop-and-wait). It registers the
// result with its output index and then moves to the next window or strip.
// A result that never arrives within TIMEOUT cycles parks the block in an
// error state until abort.
//
// Ports
//   clk_i          clock
//   nreset_i       asynchronous active-low reset
//   start_i        frame start request (honoured only when idle)
//   abort_i        synchronous abort, returns to idle from any state
//   mem_rd_o       frame-memory read strobe
//   mem_addr_o     read address, row*IMG_WIDTH+col
//   mem_data_i     read data, valid one cycle after mem_rd_o
//   start_sobel_o  high while a strip is active (LOAD / WAIT_RES)
//   px_o           pixel to the Sobel controller
//   px_valid_o     px_o valid
//   sobel_rdy_i    Sobel result strobe
//   sobel_px_i     Sobel result
//   out_px_o       registered result
//   out_addr_o     output index, oy*(IMG_WIDTH-2)+ox
//   out_valid_o    one-cycle result strobe
//   busy_o         frame in progress
//   done_o         one-cycle frame-complete pulse
//   err_o          sticky timeout flag
// ---------------------------------------------------------------------------
module sobel_scheduler #(
  parameter int IMG_WIDTH   = 16,
  parameter int IMG_HEIGHT  = 16,
  parameter int PIXEL_WIDTH = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int TIMEOUT     = 15
) (
  input  logic                   clk_i,
  input  logic                   nreset_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  output logic                   mem_rd_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  input  logic [PIXEL_WIDTH-1:0] mem_data_i,
  output logic                   start_sobel_o,
  output logic [PIXEL_WIDTH-1:0] px_o,
  output logic                   px_valid_o,
  input  logic                   sobel_rdy_i,
  input  logic [PIXEL_WIDTH-1:0] sobel_px_i,
  output logic [PIXEL_WIDTH-1:0] out_px_o,
  output logic [ADDR_WIDTH-1:0]  out_addr_o,
  output logic                   out_valid_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [XW-1:0] X_LAST  = XW'(IMG_WIDTH - 3);
  localparam logic [XW-1:0] X_ONE   = XW'(1);
  localparam logic [YW-1:0] OY_LAST = YW'(IMG_HEIGHT - 3);
  localparam logic [YW-1:0] OY_ONE  = YW'(1);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [1:0]    COL_LAST = 2'd2;

  // Moving from (r, x+2) to (r+1, x) is a step of IMG_WIDTH-2 in memory.
  // Moving down one window row in the output index is also IMG_WIDTH-2.
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(IMG_WIDTH - 2);
  localparam logic [ADDR_WIDTH-1:0] OUT_STEP = ADDR_WIDTH'(IMG_WIDTH - 2);
  localparam logic [ADDR_WIDTH-1:0] A_ONE    = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT_RES, GAP, DONE, ERROR
  } state_t;

  state_t                 r_state;
  logic [XW-1:0]          r_x;
  logic [YW-1:0]          r_oy;
  logic [1:0]             r_col;
  logic [1:0]             r_rows_left;
  logic [TW-1:0]          r_wait;
  logic                   r_gap;
  logic                   r_mem_rd;
  logic [ADDR_WIDTH-1:0]  r_mem_addr;
  logic                   r_px_valid;
  logic                   r_start_sobel;
  logic [PIXEL_WIDTH-1:0] r_out_px;
  logic [ADDR_WIDTH-1:0]  r_out_addr;
  logic [ADDR_WIDTH-1:0]  r_oaddr;
  logic                   r_out_valid;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;

  // Memory data already arrives one cycle after the strobe. It goes straight
  // through, so only the valid flag needs delaying.
  assign px_o          = mem_data_i;
  assign px_valid_o    = r_px_valid;
  assign mem_rd_o      = r_mem_rd;
  assign mem_addr_o    = r_mem_addr;
  assign start_sobel_o = r_start_sobel;
  assign out_px_o      = r_out_px;
  assign out_addr_o    = r_out_addr;
  assign out_valid_o   = r_out_valid;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign err_o         = r_err;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_state       <= IDLE;
      r_x           <= '0;
      r_oy          <= '0;
      r_col         <= '0;
      r_rows_left   <= '0;
      r_wait        <= '0;
      r_gap         <= 1'b0;
      r_mem_rd      <= 1'b0;
      r_mem_addr    <= '0;
      r_px_valid    <= 1'b0;
      r_start_sobel <= 1'b0;
      r_out_px      <= '0;
      r_out_addr    <= '0;
      r_oaddr       <= '0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_px_valid  <= r_mem_rd & ~abort_i;

      // Abort wins over everything, including a result arriving this cycle.
      if (abort_i) begin
        r_state       <= IDLE;
        r_busy        <= 1'b0;
        r_start_sobel <= 1'b0;
        r_mem_rd      <= 1'b0;
        r_err         <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start_i) begin
              r_state       <= LOAD;
              r_busy        <= 1'b1;
              r_start_sobel <= 1'b1;
              r_mem_rd      <= 1'b1;
              r_mem_addr    <= '0;
              r_x           <= '0;
              r_oy          <= '0;
              r_col         <= '0;
              r_rows_left   <= 2'd2;
              r_oaddr       <= '0;
            end
          end

          // r_rows_left is 2 for a full 3x3 fetch and 0 for a single-row fetch.
          LOAD: begin
            if (r_col != COL_LAST) begin
              r_col      <= r_col + 2'd1;
              r_mem_addr <= r_mem_addr + A_ONE;
            end else if (r_rows_left != 2'd0) begin
              r_col       <= '0;
              r_rows_left <= r_rows_left - 2'd1;
              r_mem_addr  <= r_mem_addr + ROW_STEP;
            end else begin
              r_state  <= WAIT_RES;
              r_mem_rd <= 1'b0;
              r_wait   <= '0;
            end
          end

          WAIT_RES: begin
            if (sobel_rdy_i) begin
              r_out_px    <= sobel_px_i;
              r_out_addr  <= r_oaddr;
              r_out_valid <= 1'b1;
              r_oaddr     <= r_oaddr + OUT_STEP;
              if (r_oy != OY_LAST) begin
                r_state     <= LOAD;
                r_mem_rd    <= 1'b1;
                r_mem_addr  <= r_mem_addr + ROW_STEP;
                r_col       <= '0;
                r_rows_left <= 2'd0;
                r_oy        <= r_oy + OY_ONE;
              end else if (r_x != X_LAST) begin
                r_state       <= GAP;
                r_start_sobel <= 1'b0;
                r_gap         <= 1'b0;
              end else begin
                r_state       <= DONE;
                r_start_sobel <= 1'b0;
                r_done        <= 1'b1;
              end
            end else if (r_wait == T_LAST) begin
              r_state       <= ERROR;
              r_err         <= 1'b1;
              r_start_sobel <= 1'b0;
            end else begin
              r_wait <= r_wait + T_ONE;
            end
          end

          // The next strip starts at row 0, so its first address and first
          // output index are both the new x.
          GAP: begin
            if (r_gap) begin
              r_state       <= LOAD;
              r_start_sobel <= 1'b1;
              r_mem_rd      <= 1'b1;
              r_x           <= r_x + X_ONE;
              r_mem_addr    <= ADDR_WIDTH'(r_x) + A_ONE;
              r_oaddr       <= ADDR_WIDTH'(r_x) + A_ONE;
              r_oy          <= '0;
              r_col         <= '0;
              r_rows_left   <= 2'd2;
            end else begin
              r_gap <= 1'b1;
            end
          end

          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end

          ERROR: begin
            r_state <= ERROR;
          end

          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sobel_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sobel_scheduler
//
// Bench for sobel_scheduler. A 4x4 instance carries the main scenarios. A
// second 3x3 instance covers the single-strip frame. A behavioural model
// lists the expected read addresses and output indices for a frame. An
// automatic Sobel responder answers each finished window after a chosen or
// random delay.
// ---------------------------------------------------------------------------
module tb_sobel_scheduler;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 8;
  localparam int AW = 8;
  localparam int TO = 15;

  typedef struct {
    int lat;
    bit noise;
    bit expErr;
    int expReads;
    int expResults;
    int expDone;
    int expGaps;
  } vec_t;

  logic clk = 1'b0;
  logic nreset;

  logic          startA, abortA, rdyA, autoRdyA, manRdy, rspOn;
  logic [PW-1:0] sPxA, memDataA, pxA, outPxA;
  logic [AW-1:0] memAddrA, outAddrA;
  logic          memRdA, startSobelA, pxValidA, outValidA, busyA, doneA, errA;

  logic          startB, abortB, rdyB;
  logic [PW-1:0] sPxB, memDataB, pxB, outPxB;
  logic [AW-1:0] memAddrB, outAddrB;
  logic          memRdB, startSobelB, pxValidB, outValidB, busyB, doneB, errB;

  logic [PW-1:0] memA [0:(1<<AW)-1];

  int  errors = 0;
  int  checks = 0;
  int  rdQ[$], pxQ[$], oaQ[$], opQ[$], sentQ[$];
  int  doneCnt, gapCnt;
  int  rdBQ[$], pxBQ[$], oaBQ[$], opBQ[$];
  int  doneCntB, gapCntB;
  int  expRd[$], expOa[$];
  bit  rspRand;
  int  rspLat;
  vec_t vecs [5];
  int  spec26 [24] = '{0,1,2,4,5,6,8,9,10,12,13,14,1,2,3,5,6,7,9,10,11,13,14,15};
  int  specOa [4]  = '{0,2,1,3};

  always #5 clk = ~clk;

  assign rdyA = rspOn ? autoRdyA : manRdy;
  assign sPxB = 8'h5A;
  assign abortB = 1'b0;

  sobel_scheduler #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(PW),
                    .ADDR_WIDTH(AW), .TIMEOUT(TO)) dutA (
    .clk_i(clk), .nreset_i(nreset), .start_i(startA), .abort_i(abortA),
    .mem_rd_o(memRdA), .mem_addr_o(memAddrA), .mem_data_i(memDataA),
    .start_sobel_o(startSobelA), .px_o(pxA), .px_valid_o(pxValidA),
    .sobel_rdy_i(rdyA), .sobel_px_i(sPxA), .out_px_o(outPxA),
    .out_addr_o(outAddrA), .out_valid_o(outValidA), .busy_o(busyA),
    .done_o(doneA), .err_o(errA));

  sobel_scheduler #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .PIXEL_WIDTH(PW),
                    .ADDR_WIDTH(AW), .TIMEOUT(TO)) dutB (
    .clk_i(clk), .nreset_i(nreset), .start_i(startB), .abort_i(abortB),
    .mem_rd_o(memRdB), .mem_addr_o(memAddrB), .mem_data_i(memDataB),
    .start_sobel_o(startSobelB), .px_o(pxB), .px_valid_o(pxValidB),
    .sobel_rdy_i(rdyB), .sobel_px_i(sPxB), .out_px_o(outPxB),
    .out_addr_o(outAddrB), .out_valid_o(outValidB), .busy_o(busyB),
    .done_o(doneB), .err_o(errB));

  // Synchronous-read frame memories: data one cycle after the strobe.
  always @(posedge clk) if (memRdA) memDataA <= memA[memAddrA];
  always @(posedge clk) if (memRdB) memDataB <= PW'(memAddrB);

  // Monitor and automatic responder for instance A. A window is finished
  // when px_valid falls while the strip is still active. The result is
  // returned 'lat' cycles after that point.
  initial begin : monA
    bit prevPxv;
    int pending;
    int delay;
    prevPxv = 1'b0; pending = 0; delay = 0;
    autoRdyA = 1'b0; sPxA = '0;
    forever begin
      @(negedge clk);
      if (memRdA) rdQ.push_back(int'(memAddrA));
      if (pxValidA) pxQ.push_back(int'(pxA));
      if (outValidA) begin
        oaQ.push_back(int'(outAddrA));
        opQ.push_back(int'(outPxA));
      end
      if (doneA) doneCnt++;
      if (busyA && !startSobelA && !doneA && !errA) gapCnt++;
      if (rspOn) begin
        autoRdyA = 1'b0;
        if (prevPxv && !pxValidA && startSobelA) begin
          pending = 1;
          delay = rspRand ? int'($urandom_range(0, 10)) : rspLat;
        end
        if (pending != 0) begin
          if (delay == 0) begin
            autoRdyA = 1'b1;
            sPxA = PW'($urandom);
            sentQ.push_back(int'(sPxA));
            pending = 0;
          end else begin
            delay--;
          end
        end
      end else begin
        pending = 0;
        autoRdyA = 1'b0;
      end
      prevPxv = pxValidA;
    end
  end

  // Monitor and immediate responder for the 3x3 instance.
  initial begin : monB
    bit prevB;
    prevB = 1'b0;
    rdyB = 1'b0;
    forever begin
      @(negedge clk);
      if (memRdB) rdBQ.push_back(int'(memAddrB));
      if (pxValidB) pxBQ.push_back(int'(pxB));
      if (outValidB) begin
        oaBQ.push_back(int'(outAddrB));
        opBQ.push_back(int'(outPxB));
      end
      if (doneB) doneCntB++;
      if (busyB && !startSobelB && !doneB && !errB) gapCntB++;
      rdyB = prevB && !pxValidB && startSobelB;
      prevB = pxValidB;
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference frame: each strip covers all rows once, three columns per
  // row. Each strip yields one output per window row.
  function automatic void buildModel(input int w, input int h);
    expRd.delete();
    expOa.delete();
    for (int x = 0; x <= w - 3; x++) begin
      for (int r = 0; r < h; r++)
        for (int c = 0; c < 3; c++)
          expRd.push_back(r * w + x + c);
      for (int oy = 0; oy <= h - 3; oy++)
        expOa.push_back(oy * (w - 2) + x);
    end
  endfunction

  task automatic applyStimulus(input int lat, input bit rnd, input bit noise);
    bit finished;
    rspOn = 1'b0;
    @(negedge clk);
    rdQ.delete(); pxQ.delete(); oaQ.delete(); opQ.delete(); sentQ.delete();
    doneCnt = 0; gapCnt = 0;
    rspLat = lat; rspRand = rnd; rspOn = 1'b1;
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    finished = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (doneA || errA) begin
        finished = 1'b1;
        break;
      end
      if (noise) startA = ($urandom_range(0, 3) == 0);
    end
    startA = 1'b0;
    checkOutput("frameEnds", 32'(finished), 1);
    if (doneA) begin
      @(negedge clk);
      checkOutput("busyAfterDone", 32'(busyA), 0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic verifyFrame(input vec_t v, input bit specSeq);
    checkOutput("errFlag", 32'(errA), 32'(v.expErr));
    checkOutput("readCount", rdQ.size(), v.expReads);
    checkOutput("resultCount", oaQ.size(), v.expResults);
    checkOutput("doneCount", doneCnt, v.expDone);
    checkOutput("gapCycles", gapCnt, v.expGaps);
    for (int k = 0; k < rdQ.size() && k < expRd.size(); k++)
      checkOutput($sformatf("rdAddr[%0d]", k), rdQ[k], expRd[k]);
    for (int k = 0; k < pxQ.size() && k < expRd.size(); k++)
      checkOutput($sformatf("pixel[%0d]", k), pxQ[k], int'(memA[expRd[k]]));
    for (int k = 0; k < oaQ.size() && k < expOa.size(); k++)
      checkOutput($sformatf("outAddr[%0d]", k), oaQ[k], expOa[k]);
    for (int k = 0; k < opQ.size() && k < sentQ.size(); k++)
      checkOutput($sformatf("outPx[%0d]", k), opQ[k], sentQ[k]);
    if (specSeq) begin
      for (int k = 0; k < rdQ.size() && k < 24; k++)
        checkOutput($sformatf("specAddr[%0d]", k), rdQ[k], spec26[k]);
      for (int k = 0; k < oaQ.size() && k < 4; k++)
        checkOutput($sformatf("specOut[%0d]", k), oaQ[k], specOa[k]);
    end
  endtask

  initial begin : main
    vec_t normal;
    bit   seen;
    nreset = 1'b0; startA = 1'b0; abortA = 1'b0; startB = 1'b0;
    manRdy = 1'b0; rspOn = 1'b0; rspRand = 1'b0; rspLat = 0;
    doneCnt = 0; gapCnt = 0; doneCntB = 0; gapCntB = 0;
    for (int a = 0; a < (1 << AW); a++) memA[a] = PW'(a);

    //          lat noise err reads results done gaps
    vecs[0] = '{1,  0,    0,  24,   4,      1,   2};
    vecs[1] = '{0,  1,    0,  24,   4,      1,   2};
    vecs[2] = '{13, 0,    0,  24,   4,      1,   2};
    vecs[3] = '{14, 0,    1,  9,    0,      0,   0};
    vecs[4] = '{6,  1,    0,  24,   4,      1,   2};
    normal  = vecs[0];

    repeat (3) @(negedge clk);
    checkOutput("resetCtrlA", 32'({busyA, doneA, errA, memRdA, startSobelA,
                                  pxValidA, outValidA}), 0);
    checkOutput("resetDataA", 32'({memAddrA, outAddrA, outPxA}), 0);
    checkOutput("resetCtrlB", 32'({busyB, doneB, errB, memRdB, startSobelB,
                                  pxValidB, outValidB}), 0);
    nreset = 1'b1;
    repeat (2) @(negedge clk);

    buildModel(W, H);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].lat, 1'b0, vecs[i].noise);
      verifyFrame(vecs[i], i == 0);
      if (vecs[i].expErr) begin
        repeat (5) @(negedge clk);
        checkOutput("readsStopped", rdQ.size(), 9);
        checkOutput("busyInError", 32'(busyA), 1);
        checkOutput("errHeld", 32'(errA), 1);
        checkOutput("rdyIgnoredInError", oaQ.size(), 0);
        abortA = 1'b1;
        @(negedge clk);
        abortA = 1'b0;
        checkOutput("busyAfterAbort", 32'(busyA), 0);
        checkOutput("errAfterAbort", 32'(errA), 0);
        repeat (2) @(negedge clk);
      end
    end

    // Abort together with a result in WAIT_RES. sobel_rdy is also held
    // high during LOAD, where it must be ignored.
    rspOn = 1'b0;
    @(negedge clk);
    rdQ.delete(); oaQ.delete();
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (startSobelA && !memRdA && !pxValidA) begin
        seen = 1'b1;
        manRdy = 1'b1;
        abortA = 1'b1;
        break;
      end
      manRdy = memRdA;
    end
    checkOutput("waitResSeen", 32'(seen), 1);
    @(negedge clk);
    manRdy = 1'b0;
    abortA = 1'b0;
    checkOutput("abortNoOutValid", 32'(outValidA), 0);
    checkOutput("abortBusy", 32'(busyA), 0);
    checkOutput("abortStartSobel", 32'(startSobelA), 0);
    @(negedge clk);
    checkOutput("abortResults", oaQ.size(), 0);
    checkOutput("abortReads", rdQ.size(), 9);

    // Asynchronous reset in the middle of the second strip.
    rspOn = 1'b0;
    @(negedge clk);
    rdQ.delete();
    rspLat = 0; rspRand = 1'b0; rspOn = 1'b1;
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    for (int c = 0; c < 200 && rdQ.size() < 14; c++) @(negedge clk);
    checkOutput("reachedStrip2", 32'(rdQ.size() >= 14), 1);
    #2 nreset = 1'b0;
    #1 checkOutput("asyncResetCtrl", 32'({busyA, memRdA, startSobelA,
                                         pxValidA, errA}), 0);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0);
    verifyFrame(normal, 1'b1);

    // Randomized frames with random memory contents, random result delays
    // and stray start requests.
    for (int f = 0; f < 3; f++) begin
      for (int a = 0; a < (1 << AW); a++) memA[a] = PW'($urandom);
      applyStimulus(0, 1'b1, 1'b1);
      verifyFrame(normal, 1'b0);
    end

    // 3x3 frame: one strip, one window, no gap.
    rdBQ.delete(); pxBQ.delete(); oaBQ.delete(); opBQ.delete();
    doneCntB = 0; gapCntB = 0;
    startB = 1'b1;
    @(negedge clk);
    startB = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (doneB) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("frameEndsB", 32'(seen), 1);
    repeat (2) @(negedge clk);
    checkOutput("readCountB", rdBQ.size(), 9);
    for (int k = 0; k < rdBQ.size() && k < 9; k++)
      checkOutput($sformatf("rdAddrB[%0d]", k), rdBQ[k], k);
    for (int k = 0; k < pxBQ.size() && k < 9; k++)
      checkOutput($sformatf("pixelB[%0d]", k), pxBQ[k], k);
    checkOutput("resultCountB", oaBQ.size(), 1);
    if (oaBQ.size() > 0) begin
      checkOutput("outAddrB", oaBQ[0], 0);
      checkOutput("outPxB", opBQ[0], 32'h5A);
    end
    checkOutput("gapCyclesB", gapCntB, 0);
    checkOutput("doneCountB", doneCntB, 1);
    checkOutput("busyAfterDoneB", 32'(busyB), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
